// File: rtl/kv_pkg.sv
// Shared opcodes, response statuses and FSM encoding for the kv_table key-value store.
// KV_DELETE_EN (when defined) makes op 3 a legal DELETE.
package kv_pkg;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_PUT  = 2'd1;
  localparam logic [1:0] OP_GET  = 2'd2;
  localparam logic [1:0] OP_DEL  = 2'd3;

  localparam logic [1:0] ST_OK_NEW    = 2'd0;
  localparam logic [1:0] ST_OK_HIT    = 2'd1;
  localparam logic [1:0] ST_NOT_FOUND = 2'd2;
  localparam logic [1:0] ST_ERR       = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } kv_state_e;

  function automatic logic op_legal(input logic [1:0] op);
`ifdef KV_DELETE_EN
    return (op != OP_NONE);
`else
    return (op != OP_NONE) && (op != OP_DEL);
`endif
  endfunction

endpackage

// File: rtl/kv_slot_ram.sv
// Key/value storage for kv_table: DEPTH x W register array, combinational read, one write port.
// Not reset; slot validity is tracked by the owner.
module kv_slot_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Single synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/kv_table.sv
// Linear-scan key-value table: PUT/GET (and DELETE when KV_DELETE_EN is defined),
// one response per command, valid bits and occupancy kept here so they reset.
module kv_table
  import kv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int KEY_W = 32,
  parameter int VAL_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [KEY_W-1:0]       cmd_key,
  input  logic [VAL_W-1:0]       cmd_value,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_status,
  output logic [VAL_W-1:0]       rsp_value,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_ONE  = {{(OCC_W-1){1'b0}}, 1'b1};

  kv_state_e          state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   hit_idx_r;
  logic [IDX_W-1:0]   free_idx_r;
  logic               hit_r;
  logic               free_found_r;
  logic [1:0]         op_r;
  logic [KEY_W-1:0]   key_r;
  logic [VAL_W-1:0]   val_r;
  logic [VAL_W-1:0]   hit_val_r;
  logic [DEPTH-1:0]   valid_r;
  logic [OCC_W-1:0]   occ_r;
  logic               cmd_ready_r;
  logic               rsp_valid_r;
  logic [1:0]         rsp_status_r;
  logic [VAL_W-1:0]   rsp_value_r;

  logic [KEY_W+VAL_W-1:0] rd_data_s;
  logic [KEY_W-1:0]       rd_key_s;
  logic [VAL_W-1:0]       rd_val_s;
  logic                   slot_hit_s;
  logic                   we_s;
  logic [IDX_W-1:0]       waddr_s;

  assign rd_key_s   = rd_data_s[KEY_W+VAL_W-1:VAL_W];
  assign rd_val_s   = rd_data_s[VAL_W-1:0];
  assign slot_hit_s = valid_r[idx_r] && (rd_key_s == key_r);

  // A hit rewrites the same slot (key unchanged); a miss fills the lowest free slot
  assign we_s    = (state_r == S_COMMIT) && (op_r == OP_PUT) && (hit_r || free_found_r);
  assign waddr_s = hit_r ? hit_idx_r : free_idx_r;

  kv_slot_ram #(.DEPTH(DEPTH), .W(KEY_W + VAL_W)) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata ({key_r, val_r}),
    .raddr (idx_r),
    .rdata (rd_data_s)
  );

  // Command FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      idx_r        <= {IDX_W{1'b0}};
      hit_idx_r    <= {IDX_W{1'b0}};
      free_idx_r   <= {IDX_W{1'b0}};
      hit_r        <= 1'b0;
      free_found_r <= 1'b0;
      op_r         <= OP_NONE;
      key_r        <= {KEY_W{1'b0}};
      val_r        <= {VAL_W{1'b0}};
      hit_val_r    <= {VAL_W{1'b0}};
      valid_r      <= {DEPTH{1'b0}};
      occ_r        <= {OCC_W{1'b0}};
      cmd_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_status_r <= ST_OK_NEW;
      rsp_value_r  <= {VAL_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            op_r         <= cmd_op;
            key_r        <= cmd_key;
            val_r        <= cmd_value;
            idx_r        <= {IDX_W{1'b0}};
            hit_r        <= 1'b0;
            free_found_r <= 1'b0;
            cmd_ready_r  <= 1'b0;
            if (op_legal(cmd_op)) begin
              state_r <= S_SCAN;
            end else begin
              // rsp_valid rises one cycle later, from RESP itself
              state_r      <= S_RESP;
              rsp_status_r <= ST_ERR;
              rsp_value_r  <= {VAL_W{1'b0}};
            end
          end
        end
        S_SCAN: begin
          if (slot_hit_s) begin
            hit_r     <= 1'b1;
            hit_idx_r <= idx_r;
            hit_val_r <= rd_val_s;
            state_r   <= S_COMMIT;
          end else begin
            if (!valid_r[idx_r] && !free_found_r) begin
              free_found_r <= 1'b1;
              free_idx_r   <= idx_r;
            end
            if (idx_r == IDX_LAST) begin
              state_r <= S_COMMIT;
            end else begin
              idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        S_COMMIT: begin
          state_r     <= S_RESP;
          rsp_valid_r <= 1'b1;
          case (op_r)
            OP_PUT: begin
              if (hit_r) begin
                rsp_status_r <= ST_OK_HIT;
                rsp_value_r  <= val_r;
              end else if (free_found_r) begin
                valid_r[free_idx_r] <= 1'b1;
                occ_r        <= occ_r + OCC_ONE;
                rsp_status_r <= ST_OK_NEW;
                rsp_value_r  <= val_r;
              end else begin
                rsp_status_r <= ST_ERR;
                rsp_value_r  <= {VAL_W{1'b0}};
              end
            end
            OP_GET: begin
              rsp_status_r <= hit_r ? ST_OK_HIT : ST_NOT_FOUND;
              rsp_value_r  <= hit_r ? hit_val_r : {VAL_W{1'b0}};
            end
`ifdef KV_DELETE_EN
            OP_DEL: begin
              if (hit_r) begin
                valid_r[hit_idx_r] <= 1'b0;
                occ_r        <= occ_r - OCC_ONE;
                rsp_status_r <= ST_OK_HIT;
                rsp_value_r  <= hit_val_r;
              end else begin
                rsp_status_r <= ST_NOT_FOUND;
                rsp_value_r  <= {VAL_W{1'b0}};
              end
            end
`endif
            default: begin
              rsp_status_r <= ST_ERR;
              rsp_value_r  <= {VAL_W{1'b0}};
            end
          endcase
        end
        S_RESP: begin
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cmd_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_status = rsp_status_r;
  assign rsp_value  = rsp_value_r;
  assign occupancy  = occ_r;

endmodule

// File: tb/tb_kv_table.sv
// Randomized self-checking bench for kv_table against a slot-array reference model.
// Honours KV_DELETE_EN the same way as the design.
module tb_kv_table;

  localparam int DEPTH = 16;
  localparam int KEY_W = 32;
  localparam int VAL_W = 32;
`ifdef KV_DELETE_EN
  localparam bit DEL_EN = 1'b1;
`else
  localparam bit DEL_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [KEY_W-1:0] cmd_key;
  logic [VAL_W-1:0] cmd_value;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_status;
  logic [VAL_W-1:0] rsp_value;
  logic [4:0]       occupancy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: slot array with lowest-free insertion
  bit         m_valid [DEPTH];
  bit [31:0]  m_key   [DEPTH];
  bit [31:0]  m_val   [DEPTH];

  kv_table #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_key    (cmd_key),
    .cmd_value  (cmd_value),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_value  (rsp_value),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_valid[i];
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_exec(input bit [1:0] op, input bit [31:0] key, input bit [31:0] val,
                            output bit [1:0] st, output bit [31:0] v, output int lat);
    int hit = -1;
    int fr = -1;
    bit legal = (op == 2'd1) || (op == 2'd2) || (DEL_EN && op == 2'd3);
    st = 2'd3; v = 32'd0; lat = 1;
    if (legal) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (hit < 0 && m_valid[i] && m_key[i] == key) hit = i;
        if (fr < 0 && !m_valid[i]) fr = i;
      end
      lat = (hit >= 0) ? hit + 2 : DEPTH + 1;
      if (op == 2'd1) begin
        if (hit >= 0) begin
          m_val[hit] = val; st = 2'd1; v = val;
        end else if (fr >= 0) begin
          m_valid[fr] = 1'b1; m_key[fr] = key; m_val[fr] = val; st = 2'd0; v = val;
        end else begin
          st = 2'd3; v = 32'd0;
        end
      end else if (op == 2'd2) begin
        st = (hit >= 0) ? 2'd1 : 2'd2;
        v  = (hit >= 0) ? m_val[hit] : 32'd0;
      end else begin
        if (hit >= 0) begin
          m_valid[hit] = 1'b0; st = 2'd1; v = m_val[hit];
        end else begin
          st = 2'd2; v = 32'd0;
        end
      end
    end
  endtask

  // issue one command, measure latency, optionally stall the response, compare to model
  task automatic do_cmd(input bit [1:0] op, input bit [31:0] key, input bit [31:0] val,
                        input int hold);
    bit [1:0]  exp_st;
    bit [31:0] exp_v;
    int        exp_lat;
    int        lat;
    int        w;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check_eq("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
      return;
    end
    model_exec(op, key, val, exp_st, exp_v, exp_lat);
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_value = val;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_key = $urandom; cmd_value = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 100);
    if (!rsp_valid) begin
      check_eq("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("status", 64'(rsp_status), 64'(exp_st));
    check_eq("value", 64'(rsp_value), 64'(exp_v));
    check_eq("occupancy", 64'(occupancy), 64'(model_occ()));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", {63'd0, rsp_valid}, 64'd1);
      check_eq("hold_status", 64'(rsp_status), 64'(exp_st));
      check_eq("hold_value", 64'(rsp_value), 64'(exp_v));
      check_eq("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_eq("rsp_dropped", {63'd0, rsp_valid}, 64'd0);
    check_eq("ready_after", {63'd0, cmd_ready}, 64'd1);
  endtask

  task automatic random_cmds(input int n);
    bit [1:0] op;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      op = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
      do_cmd(op, 32'hA000_0000 + 32'($urandom_range(0, 19)), $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_key = '0; cmd_value = '0; rsp_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_status", 64'(rsp_status), 64'd0);
    check_eq("rst_value", 64'(rsp_value), 64'd0);
    check_eq("rst_occ", 64'(occupancy), 64'd0);

    do_cmd(2'd1, 32'h11, 32'hAA, 0);
    do_cmd(2'd2, 32'h11, 32'h0, 0);
    do_cmd(2'd2, 32'h22, 32'h0, 1);
    do_cmd(2'd1, 32'h11, 32'hBB, 0);
    do_cmd(2'd2, 32'h11, 32'h0, 0);
    do_cmd(2'd0, 32'h11, 32'h5, 0);
    do_cmd(2'd3, 32'h11, 32'h0, 0);
    do_cmd(2'd1, 32'h11, 32'hCC, 0);

    for (int i = 0; model_occ() < DEPTH; i++) do_cmd(2'd1, 32'h100 + 32'(i), $urandom, 0);
    do_cmd(2'd1, 32'hDEAD, 32'h77, 5);
    do_cmd(2'd2, 32'h10F, 32'h0, 0);
    random_cmds(60);

    // asynchronous reset in the middle of a long scan
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_key = 32'hFFFF_0000; cmd_value = 32'd0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_eq("midrst_occ", 64'(occupancy), 64'd0);
    check_eq("midrst_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      check_eq("midrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    check_eq("midrst_ready", {63'd0, cmd_ready}, 64'd1);
    do_cmd(2'd2, 32'h11, 32'h0, 0);
    random_cmds(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
